// File: rtl/vga_pkg.sv
// ============================================================================
// vga_pkg : shared widths, video timing presets, palette and pipeline types
// Rev 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

   localparam int MA_W  = 9;
   localparam int TA_W  = 11;
   localparam int RGB_W = 12;
   localparam int CNT_W = 12;

   // 640x480 @ 60 Hz
   localparam int VGA640_RES_H  = 640;
   localparam int VGA640_FP_H   = 16;
   localparam int VGA640_SYNC_H = 96;
   localparam int VGA640_BP_H   = 48;
   localparam int VGA640_RES_V  = 480;
   localparam int VGA640_FP_V   = 10;
   localparam int VGA640_SYNC_V = 2;
   localparam int VGA640_BP_V   = 33;

   // 720x400 text mode (936 x 449 totals)
   localparam int VGA720X400_RES_H  = 720;
   localparam int VGA720X400_FP_H   = 36;
   localparam int VGA720X400_SYNC_H = 72;
   localparam int VGA720X400_BP_H   = 108;
   localparam int VGA720X400_RES_V  = 400;
   localparam int VGA720X400_FP_V   = 12;
   localparam int VGA720X400_SYNC_V = 3;
   localparam int VGA720X400_BP_V   = 34;

   // 720x480 (858 x 525 totals)
   localparam int VGA720X480_RES_H  = 720;
   localparam int VGA720X480_FP_H   = 16;
   localparam int VGA720X480_SYNC_H = 62;
   localparam int VGA720X480_BP_H   = 60;
   localparam int VGA720X480_RES_V  = 480;
   localparam int VGA720X480_FP_V   = 9;
   localparam int VGA720X480_SYNC_V = 6;
   localparam int VGA720X480_BP_V   = 30;

   localparam logic [RGB_W-1:0] BORDER = 12'h224;

   typedef struct packed {
      logic       vis;
      logic       hsync;
      logic       vsync;
      logic       win;
      logic [2:0] c;
      logic [2:0] r;
      logic       frame;
   } pipe_t;

   function automatic logic [RGB_W-1:0] palette(input logic [1:0] idx);
      case (idx)
         2'd0:    palette = 12'h000;
         2'd1:    palette = 12'h0A0;
         2'd2:    palette = 12'hFA0;
         default: palette = 12'hFFF;
      endcase
   endfunction

   // Pixel 0 of a tile row sits in the two MSBs of the word.
   function automatic logic [1:0] pixel_index(input logic [15:0] word, input logic [2:0] col);
      logic [15:0] shifted;
      shifted = word << {col, 1'b0};
      return shifted[15:14];
   endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing.sv
// ============================================================================
// vga_timing : h/v raster counters with raw visible, sync and frame flags
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_timing
   import vga_pkg::*;
#(
   parameter int res_H  = VGA640_RES_H,
   parameter int fp_H   = VGA640_FP_H,
   parameter int sync_H = VGA640_SYNC_H,
   parameter int bp_H   = VGA640_BP_H,
   parameter int res_V  = VGA640_RES_V,
   parameter int fp_V   = VGA640_FP_V,
   parameter int sync_V = VGA640_SYNC_V,
   parameter int bp_V   = VGA640_BP_V
)
(
   input  logic             clock,
   input  logic             reset,
   output logic [CNT_W-1:0] o_h,
   output logic [CNT_W-1:0] o_v,
   output logic             o_visible,
   output logic             o_hsync,
   output logic             o_vsync,
   output logic             o_frame_start
);

   localparam logic [CNT_W-1:0] c_H_RES      = CNT_W'(res_H);
   localparam logic [CNT_W-1:0] c_H_LAST     = CNT_W'(res_H + fp_H + sync_H + bp_H - 1);
   localparam logic [CNT_W-1:0] c_HS_START   = CNT_W'(res_H + fp_H);
   localparam logic [CNT_W-1:0] c_HS_END     = CNT_W'(res_H + fp_H + sync_H);
   localparam logic [CNT_W-1:0] c_V_RES      = CNT_W'(res_V);
   localparam logic [CNT_W-1:0] c_V_LAST     = CNT_W'(res_V + fp_V + sync_V + bp_V - 1);
   localparam logic [CNT_W-1:0] c_VS_START   = CNT_W'(res_V + fp_V);
   localparam logic [CNT_W-1:0] c_VS_END     = CNT_W'(res_V + fp_V + sync_V);

   logic [CNT_W-1:0] r_h;
   logic [CNT_W-1:0] r_v;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_h <= '0;
         r_v <= '0;
      end else if (r_h == c_H_LAST) begin
         r_h <= '0;
         r_v <= (r_v == c_V_LAST) ? '0 : r_v + 1'b1;
      end else begin
         r_h <= r_h + 1'b1;
      end
   end

   assign o_h           = r_h;
   assign o_v           = r_v;
   assign o_visible     = (r_h < c_H_RES) && (r_v < c_V_RES);
   assign o_hsync       = (r_h >= c_HS_START) && (r_h < c_HS_END);
   assign o_vsync       = (r_v >= c_VS_START) && (r_v < c_VS_END);
   assign o_frame_start = (r_h == '0) && (r_v == '0);

endmodule

`default_nettype wire

// File: rtl/vga_tile_renderer.sv
// ============================================================================
// vga_tile_renderer : 5-stage tile fetch pipeline (map -> tile -> palette)
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_tile_renderer
   import vga_pkg::*;
#(
   parameter int res_H  = VGA640_RES_H,
   parameter int fp_H   = VGA640_FP_H,
   parameter int sync_H = VGA640_SYNC_H,
   parameter int bp_H   = VGA640_BP_H,
   parameter bit neg_H  = 1'b1,
   parameter int res_V  = VGA640_RES_V,
   parameter int fp_V   = VGA640_FP_V,
   parameter int sync_V = VGA640_SYNC_V,
   parameter int bp_V   = VGA640_BP_V,
   parameter bit neg_V  = 1'b1
)
(
   input  logic            clock,
   input  logic            reset,
   input  logic [7:0]      MD,
   input  logic [15:0]     TD,
   output logic [MA_W-1:0] MA,
   output logic [TA_W-1:0] TA,
   output logic [3:0]      R,
   output logic [3:0]      G,
   output logic [3:0]      B,
   output logic            hs,
   output logic            vs,
   output logic            de,
   output logic            frame
);

   logic [CNT_W-1:0] w_h;
   logic [CNT_W-1:0] w_v;
   logic             w_visible;
   logic             w_hsync;
   logic             w_vsync;
   logic             w_frame_start;
   pipe_t            w_stage0;
   logic [1:0]       w_index;
   logic [RGB_W-1:0] w_colour;

   pipe_t            r_pipe [4];
   logic [MA_W-1:0]  r_ma;
   logic [TA_W-1:0]  r_ta;
   logic [RGB_W-1:0] r_rgb;
   logic             r_hs;
   logic             r_vs;
   logic             r_de;
   logic             r_frame;

   vga_timing #(
      .res_H  (res_H),
      .fp_H   (fp_H),
      .sync_H (sync_H),
      .bp_H   (bp_H),
      .res_V  (res_V),
      .fp_V   (fp_V),
      .sync_V (sync_V),
      .bp_V   (bp_V)
   ) u_timing (
      .clock         (clock),
      .reset         (reset),
      .o_h           (w_h),
      .o_v           (w_v),
      .o_visible     (w_visible),
      .o_hsync       (w_hsync),
      .o_vsync       (w_vsync),
      .o_frame_start (w_frame_start)
   );

   always_comb begin
      w_stage0.vis   = w_visible;
      w_stage0.hsync = w_hsync;
      w_stage0.vsync = w_vsync;
      w_stage0.win   = (w_h < CNT_W'(512)) && (w_v < CNT_W'(256));
      w_stage0.c     = w_h[3:1];
      w_stage0.r     = w_v[3:1];
      w_stage0.frame = w_frame_start;
   end

   // Stage 4 lines up with TD, so its column selects the pixel from the word.
   always_comb begin
      w_index  = pixel_index(TD, r_pipe[3].c);
      w_colour = r_pipe[3].win ? palette(w_index) : BORDER;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_pipe  <= '{default: '0};
         r_ma    <= '0;
         r_ta    <= '0;
         r_rgb   <= '0;
         r_hs    <= neg_H;
         r_vs    <= neg_V;
         r_de    <= 1'b0;
         r_frame <= 1'b0;
      end else begin
         r_pipe[0] <= w_stage0;
         r_pipe[1] <= r_pipe[0];
         r_pipe[2] <= r_pipe[1];
         r_pipe[3] <= r_pipe[2];
         r_ma      <= {w_v[7:4], w_h[8:4]};
         r_ta      <= {MD, r_pipe[1].r};
         r_rgb     <= r_pipe[3].vis ? w_colour : '0;
         r_hs      <= r_pipe[3].hsync ^ neg_H;
         r_vs      <= r_pipe[3].vsync ^ neg_V;
         r_de      <= r_pipe[3].vis;
         r_frame   <= r_pipe[3].frame;
      end
   end

   assign MA    = r_ma;
   assign TA    = r_ta;
   assign R     = r_rgb[11:8];
   assign G     = r_rgb[7:4];
   assign B     = r_rgb[3:0];
   assign hs    = r_hs;
   assign vs    = r_vs;
   assign de    = r_de;
   assign frame = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_vga_tile_renderer.sv
// ============================================================================
// tb_vga_tile_renderer : directed checks on a 640x480 instance and a small
// 16x260 instance (22 x 265 totals, active-high syncs) sharing one clock.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vga_tile_renderer;

   logic        clk = 1'b0;
   logic        rst;
   logic        rst_s;
   logic [7:0]  md, md_s;
   logic [15:0] td, td_s;
   logic [8:0]  ma, ma_s;
   logic [10:0] ta, ta_s;
   logic [3:0]  r, g, b, r_s, g_s, b_s;
   logic        hs, vs, de, frame;
   logic        hs_s, vs_s, de_s, frame_s;
   logic [11:0] rgb, rgb_s;
   int          mode;
   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;

   always #5 clk = ~clk;

   assign rgb   = {r, g, b};
   assign rgb_s = {r_s, g_s, b_s};

   // Synchronous BRAM models: one cycle read latency.
   always @(posedge clk) begin
      md   <= (mode == 2) ? 8'h07 : ((ma == 9'd0) ? 8'h05 : 8'h00);
      td   <= (mode == 2) ? 16'hAAAA : ((ta == 11'd40) ? 16'hC000 : 16'h0000);
      md_s <= 8'h03;
      td_s <= 16'hAAAA;
   end

   vga_tile_renderer u_dut (
      .clock (clk), .reset (rst), .MD (md), .TD (td), .MA (ma), .TA (ta),
      .R (r), .G (g), .B (b), .hs (hs), .vs (vs), .de (de), .frame (frame)
   );

   vga_tile_renderer #(
      .res_H (16), .fp_H (2), .sync_H (2), .bp_H (2), .neg_H (1'b0),
      .res_V (260), .fp_V (1), .sync_V (3), .bp_V (1), .neg_V (1'b0)
   ) u_small (
      .clock (clk), .reset (rst_s), .MD (md_s), .TD (td_s), .MA (ma_s), .TA (ta_s),
      .R (r_s), .G (g_s), .B (b_s), .hs (hs_s), .vs (vs_s), .de (de_s), .frame (frame_s)
   );

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic advance_to(input int t);
      while (cyc < t) step();
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      rst_s = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      tests++;
      if ({de, frame, rgb, ma, ta} !== 33'd0) begin
         fails++;
         $display("FAIL reset_outputs: got de=%b frame=%b rgb=%h ma=%h ta=%h, expected all zero", de, frame, rgb, ma, ta);
      end
      tests++;
      if ({hs, vs} !== 2'b11) begin
         fails++;
         $display("FAIL reset_sync_main: got hs=%b vs=%b expected 1 1", hs, vs);
      end
      tests++;
      if ({hs_s, vs_s, de_s} !== 3'b000) begin
         fails++;
         $display("FAIL reset_sync_small: got hs=%b vs=%b de=%b expected 0 0 0", hs_s, vs_s, de_s);
      end
      rst   = 1'b0;
      rst_s = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         tests++;
         if ({de, de_s, frame, rgb} !== 15'd0) begin
            fails++;
            $display("FAIL latency_hold: edge %0d got de=%b de_s=%b frame=%b rgb=%h expected 0", k, de, de_s, frame, rgb);
         end
      end
      @(posedge clk);
      #1;
      cyc = 0;
      tests++;
      if ({de, frame, de_s, frame_s} !== 4'b1111) begin
         fails++;
         $display("FAIL first_pixel: got de=%b frame=%b de_s=%b frame_s=%b expected 1 1 1 1", de, frame, de_s, frame_s);
      end
   endtask

   task automatic test_pixels();
      logic [11:0] exp_c;
      for (int h = 0; h < 16; h++) begin
         advance_to(h);
         exp_c = (h < 2) ? 12'hFFF : 12'h000;
         tests++;
         if (rgb !== exp_c) begin
            fails++;
            $display("FAIL line0_pixel: h=%0d got %h expected %h", h, rgb, exp_c);
         end
         if (h == 1) begin
            tests++;
            if (frame !== 1'b0) begin
               fails++;
               $display("FAIL frame_width: got frame=%b expected 0", frame);
            end
         end
      end
   endtask

   task automatic test_small_hsync();
      advance_to(17);
      tests++;
      if (hs_s !== 1'b0) begin fails++; $display("FAIL small_hs_before: got %b expected 0", hs_s); end
      advance_to(18);
      tests++;
      if (hs_s !== 1'b1) begin fails++; $display("FAIL small_hs_start: got %b expected 1", hs_s); end
      advance_to(19);
      tests++;
      if (hs_s !== 1'b1) begin fails++; $display("FAIL small_hs_hold: got %b expected 1", hs_s); end
      advance_to(20);
      tests++;
      if (hs_s !== 1'b0) begin fails++; $display("FAIL small_hs_end: got %b expected 0", hs_s); end
   endtask

   task automatic test_hsync();
      advance_to(639);
      tests++;
      if (de !== 1'b1) begin fails++; $display("FAIL de_last_visible: got %b expected 1", de); end
      advance_to(640);
      tests++;
      if ({de, rgb} !== 13'd0) begin fails++; $display("FAIL de_blank: got de=%b rgb=%h expected 0 000", de, rgb); end
      advance_to(655);
      tests++;
      if (hs !== 1'b1) begin fails++; $display("FAIL hs_before: got %b expected 1", hs); end
      advance_to(656);
      tests++;
      if (hs !== 1'b0) begin fails++; $display("FAIL hs_start: got %b expected 0", hs); end
      advance_to(751);
      tests++;
      if (hs !== 1'b0) begin fails++; $display("FAIL hs_last: got %b expected 0", hs); end
      advance_to(752);
      tests++;
      if (hs !== 1'b1) begin fails++; $display("FAIL hs_end: got %b expected 1", hs); end
      advance_to(760);
      mode = 2;
      advance_to(799);
      tests++;
      if (de !== 1'b0) begin fails++; $display("FAIL line_end: got de=%b expected 0", de); end
   endtask

   task automatic test_window();
      advance_to(800);
      tests++;
      if ({de, rgb} !== {1'b1, 12'hFA0}) begin fails++; $display("FAIL line1_start: got de=%b rgb=%h expected 1 FA0", de, rgb); end
      advance_to(1311);
      tests++;
      if (rgb !== 12'hFA0) begin fails++; $display("FAIL window_h511: got %h expected FA0", rgb); end
      advance_to(1312);
      tests++;
      if (rgb !== 12'h224) begin fails++; $display("FAIL border_h512: got %h expected 224", rgb); end
      advance_to(1439);
      tests++;
      if (rgb !== 12'h224) begin fails++; $display("FAIL border_h639: got %h expected 224", rgb); end
      advance_to(1440);
      tests++;
      if ({de, rgb} !== 13'd0) begin fails++; $display("FAIL blank_h640: got de=%b rgb=%h expected 0 000", de, rgb); end
   endtask

   task automatic test_small_frame();
      advance_to(255 * 22);
      tests++;
      if (rgb_s !== 12'hFA0) begin fails++; $display("FAIL line255: got %h expected FA0", rgb_s); end
      for (int h = 0; h < 16; h += 5) begin
         advance_to(256 * 22 + h);
         tests++;
         if (rgb_s !== 12'h224) begin fails++; $display("FAIL line256_border: h=%0d got %h expected 224", h, rgb_s); end
      end
      advance_to(256 * 22 + 16);
      tests++;
      if (rgb_s !== 12'h000) begin fails++; $display("FAIL line256_blank: got %h expected 000", rgb_s); end
      advance_to(261 * 22 - 1);
      tests++;
      if (vs_s !== 1'b0) begin fails++; $display("FAIL vs_before: got %b expected 0", vs_s); end
      advance_to(261 * 22);
      tests++;
      if (vs_s !== 1'b1) begin fails++; $display("FAIL vs_start: got %b expected 1", vs_s); end
      advance_to(264 * 22 - 1);
      tests++;
      if (vs_s !== 1'b1) begin fails++; $display("FAIL vs_last: got %b expected 1", vs_s); end
      advance_to(264 * 22);
      tests++;
      if (vs_s !== 1'b0) begin fails++; $display("FAIL vs_end: got %b expected 0", vs_s); end
      advance_to(265 * 22 - 1);
      tests++;
      if (frame_s !== 1'b0) begin fails++; $display("FAIL frame_early: got %b expected 0", frame_s); end
      advance_to(265 * 22);
      tests++;
      if ({frame_s, de_s} !== 2'b11) begin fails++; $display("FAIL frame_period: got frame=%b de=%b expected 1 1", frame_s, de_s); end
   endtask

   task automatic test_midframe_reset();
      // Counter of the small instance is now at h=10, v=100 of frame 2.
      advance_to(8035);
      tests++;
      if (ma_s !== 9'd192) begin fails++; $display("FAIL ma_before_reset: got %0d expected 192", ma_s); end
      rst_s = 1'b1;
      step();
      tests++;
      if ({ma_s, de_s, rgb_s, hs_s, vs_s} !== 24'd0) begin
         fails++;
         $display("FAIL reset_next_edge: got ma=%0d de=%b rgb=%h hs=%b vs=%b expected all 0", ma_s, de_s, rgb_s, hs_s, vs_s);
      end
      step();
      step();
      rst_s = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         tests++;
         if (de_s !== 1'b0) begin fails++; $display("FAIL rerun_hold: edge %0d got de=%b expected 0", k, de_s); end
      end
      step();
      tests++;
      if ({de_s, frame_s, rgb_s} !== {2'b11, 12'hFA0}) begin
         fails++;
         $display("FAIL rerun_first_pixel: got de=%b frame=%b rgb=%h expected 1 1 FA0", de_s, frame_s, rgb_s);
      end
      repeat (18) step();
      tests++;
      if (hs_s !== 1'b1) begin fails++; $display("FAIL rerun_hs: got %b expected 1", hs_s); end
   endtask

   initial begin
      mode  = 1;
      rst   = 1'b1;
      rst_s = 1'b1;
      test_reset();
      test_pixels();
      test_small_hsync();
      test_hsync();
      test_window();
      test_small_frame();
      test_midframe_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
